card_authorizer: RTL and testbench
==================================

# card_authorizer

Payment-side responder for the vending machine's card transaction. While a card is inserted, it captures the `COST` the vending machine presents and checks it against a stored card balance. After a fixed authorization latency it either grants (`VALID_TRAN`) or denies the transaction, and it debits the balance only when the machine reports a completed vend. It sits between the card slot/top-up logic and the vending machine, driving the machine's `VALID_TRAN` input.

## Interface
- `AUTH_LATENCY`, 2: cycles from COST capture to decision; legal range 1..4, so the machine's 5-cycle `VALID_TRAN` window is always met.
- `BAL_W`, 8: balance width in bits.
- `INIT_BALANCE`, 0: balance loaded on reset.
- `CLK` in 1: single clock; all logic on the rising edge.
- `RESET` in 1: synchronous, active-low.
- `CARD_IN` in 1: card present (level).
- `COST` in 3: price from vending machine; 0 = no pending request.
- `VEND` in 1: vend complete from machine; commits the debit.
- `FAILED_TRAN` in 1: machine aborted; releases the reservation.
- `TOPUP_EN` in 1: one-cycle strobe adding `TOPUP_AMT` to the balance.
- `TOPUP_AMT` in BAL_W: top-up amount.
- `VALID_TRAN` out 1: grant, level-held while the reservation is live.
- `DENIED` out 1: one-cycle pulse on insufficient balance.
- `BUSY` out 1: high in every state except IDLE.
- `BALANCE` out BAL_W: current committed balance.

## Operation
- States: IDLE, CHECK, GRANT, DENY_WAIT, DONE_WAIT.
- **IDLE → CHECK**: on an edge with `CARD_IN`=1 and `COST`!=0. The edge captures `COST` into the reservation register and loads the latency counter.
- **CHECK**: counts `AUTH_LATENCY` edges and ignores later `COST` changes. On the final edge it compares the current `BALANCE` (including any top-up already applied) against the captured cost.
  - `BALANCE` >= cost: go to GRANT and set `VALID_TRAN`.
  - Otherwise: go to DENY_WAIT and pulse `DENIED`.
- **GRANT**: `VALID_TRAN`=1.
  - `VEND`=1: `BALANCE` -= reserved cost, clear `VALID_TRAN`, go to DONE_WAIT.
  - `FAILED_TRAN`=1 or `CARD_IN`=0: clear `VALID_TRAN` with no debit, go to IDLE.
  - If `VEND` and `FAILED_TRAN` are both high, `VEND` wins.
- **DENY_WAIT / DONE_WAIT**: return to IDLE when `COST`=0 or `CARD_IN`=0. This prevents a double charge or a re-request on a stale `COST`.
- **CARD_IN=0 in CHECK**: abort to IDLE; no output asserts.
- **Top-up**: accepted in any state. Sum saturates at 2^BAL_W-1. If a top-up coincides with a debit, the next `BALANCE` = sat(`BALANCE` - cost + `TOPUP_AMT`), with the subtraction done first at width BAL_W+1.
- **Arithmetic**: the debit never underflows because the grant guarantees `BALANCE` >= cost. `COST` is zero-extended to BAL_W.

## Timing
- **Reset (RESET=0 at an edge)**: state IDLE, `VALID_TRAN`=0, `DENIED`=0, `BUSY`=0, `BALANCE`=INIT_BALANCE, reservation=0.
  - Reset mid-GRANT drops the reservation without a debit.
- **Decision latency**: capture at edge E0; `VALID_TRAN` or `DENIED` registered at edge E0+AUTH_LATENCY.
- **DENIED width**: exactly one cycle.
- **VALID_TRAN falling edge**: deasserts at the edge that samples `VEND`, `FAILED_TRAN` or `CARD_IN`=0.
- **BALANCE update**: changes at the same edge as `VEND` (debit) or `TOPUP_EN` (top-up). All outputs are registered.
- **BUSY**: rises at E0 and falls at the edge of return to IDLE.

## Structure
- **Shared package `card_auth_pkg`**:
  - State enum `auth_state_t`.
  - `BAL_W` default.
  - `COST_W`=3, shared with the vending machine.
- **Sub-module `auth_balance`**: the balance register with saturating add and debit. Inputs: `debit_en`, `debit_amt`, `topup_en`, `topup_amt`. Output: `balance`.
- **Top level**: the FSM, latency counter and reservation register.

## Test plan
- **Grant**: INIT_BALANCE=10, `CARD_IN`=1, `COST`=3 → `VALID_TRAN` high 2 cycles after capture; `VEND` pulse → `BALANCE`=7; `COST`=0 → IDLE.
- **Deny**: `BALANCE`=2, `COST`=5 → `DENIED` one-cycle pulse at E0+2, `VALID_TRAN` stays 0, `BALANCE`=2; no second `DENIED` while `COST` is held at 5.
- **Abort**: grant `COST`=4 with `BALANCE`=10, then `FAILED_TRAN` pulse → `VALID_TRAN` falls, `BALANCE` stays 10; repeat with `CARD_IN` dropping in CHECK → no output asserts.
- **Simultaneous events**: `BALANCE`=250 in GRANT with `COST`=6, `VEND` and `TOPUP_EN` (`TOPUP_AMT`=20) on the same edge → `BALANCE`=255 (saturated); `BALANCE`=3 in CHECK, top-up of 4 before the decision edge, `COST`=6 → granted.
- **Reset mid-operation**: `RESET`=0 during GRANT → next cycle `VALID_TRAN`=0, `BALANCE`=INIT_BALANCE, `BUSY`=0.
- **Latency sweep**: `AUTH_LATENCY`=1 and 4 → `VALID_TRAN` at E0+1 and E0+4, both within 5 cycles of capture.

Source files
------------

// File: rtl/card_auth_pkg.sv
// card_auth_pkg: shared widths and FSM state encoding for the card authorizer
package card_auth_pkg;
    localparam int BAL_W_DEFAULT = 8;
    localparam int COST_W = 3;
    typedef enum logic [2:0] {IDLE, CHECK, GRANT, DENY_WAIT, DONE_WAIT} auth_state_t;
endpackage

// File: rtl/auth_balance.sv
// auth_balance: balance register; debit applied before a saturating top-up (clk, rst_n, debit_en/amt, topup_en/amt -> balance)
module auth_balance import card_auth_pkg::*; #(
    parameter int BAL_W = BAL_W_DEFAULT,
    parameter logic [BAL_W-1:0] INIT_BALANCE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debit_en,
    input  logic [BAL_W-1:0] debit_amt,
    input  logic             topup_en,
    input  logic [BAL_W-1:0] topup_amt,
    output logic [BAL_W-1:0] balance
);
    logic [BAL_W:0] diff;
    logic [BAL_W:0] sum;
    assign diff = {1'b0, balance} - (debit_en ? {1'b0, debit_amt} : '0);
    assign sum  = diff + (topup_en ? {1'b0, topup_amt} : '0);
    always_ff @(posedge clk) begin
        if (!rst_n) balance <= INIT_BALANCE;
        else balance <= sum[BAL_W] ? '1 : sum[BAL_W-1:0];
    end
endmodule

// File: rtl/card_authorizer.sv
// card_authorizer: captures COST on card request, grants/denies after AUTH_LATENCY edges, debits on VEND; outputs VALID_TRAN, DENIED, BUSY, BALANCE
module card_authorizer import card_auth_pkg::*; #(
    parameter int AUTH_LATENCY = 2,
    parameter int BAL_W = BAL_W_DEFAULT,
    parameter int unsigned INIT_BALANCE = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CARD_IN,
    input  logic [COST_W-1:0] COST,
    input  logic              VEND,
    input  logic              FAILED_TRAN,
    input  logic              TOPUP_EN,
    input  logic [BAL_W-1:0]  TOPUP_AMT,
    output logic              VALID_TRAN,
    output logic              DENIED,
    output logic              BUSY,
    output logic [BAL_W-1:0]  BALANCE
);
    auth_state_t state, state_n;
    logic [2:0] cnt;
    logic [COST_W-1:0] resv;
    logic debit_en, denied_n, afford;
    assign afford = BALANCE >= BAL_W'(resv);
    always_comb begin
        state_n  = state;
        debit_en = 1'b0;
        denied_n = 1'b0;
        case (state)
            IDLE: state_n = (CARD_IN && COST != '0) ? CHECK : IDLE;
            CHECK: begin
                if (!CARD_IN) state_n = IDLE;
                else if (cnt == '0) begin
                    state_n  = afford ? GRANT : DENY_WAIT;
                    denied_n = !afford;
                end
            end
            GRANT: begin
                if (VEND) begin
                    state_n  = DONE_WAIT;
                    debit_en = 1'b1;
                end else if (FAILED_TRAN || !CARD_IN) state_n = IDLE;
            end
            DENY_WAIT, DONE_WAIT: state_n = (COST == '0 || !CARD_IN) ? IDLE : state;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            resv       <= '0;
            VALID_TRAN <= 1'b0;
            DENIED     <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= (state == IDLE) ? 3'(AUTH_LATENCY - 1) : (cnt == '0 ? cnt : cnt - 3'd1);
            resv       <= (state == IDLE && state_n == CHECK) ? COST : resv;
            VALID_TRAN <= state_n == GRANT;
            DENIED     <= denied_n;
            BUSY       <= state_n != IDLE;
        end
    end
    auth_balance #(.BAL_W(BAL_W), .INIT_BALANCE(BAL_W'(INIT_BALANCE))) u_bal (
        .clk(CLK),
        .rst_n(RESET),
        .debit_en(debit_en),
        .debit_amt(BAL_W'(resv)),
        .topup_en(TOPUP_EN),
        .topup_amt(TOPUP_AMT),
        .balance(BALANCE)
    );
endmodule

// File: tb/tb_card_authorizer.sv
// tb_card_authorizer: scoreboard bench for card_authorizer at latencies 2, 1 and 4
module tb_card_authorizer;
    logic clk = 1'b0;
    logic rst_n, card, vend, fail, ten;
    logic [2:0] cost;
    logic [7:0] tamt;
    logic v, d, b, v1, d1, b1, v4, d4, b4;
    logic [7:0] bal, bal1, bal4;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        string tag;
        logic v, d, b;
        logic [7:0] bal;
        bit sw;
        logic v1, v4;
    } exp_t;
    exp_t exp_q[$];
    always #5 clk = ~clk;
    card_authorizer #(.AUTH_LATENCY(2), .BAL_W(8), .INIT_BALANCE(10)) dut (
        .CLK(clk), .RESET(rst_n), .CARD_IN(card), .COST(cost), .VEND(vend), .FAILED_TRAN(fail),
        .TOPUP_EN(ten), .TOPUP_AMT(tamt), .VALID_TRAN(v), .DENIED(d), .BUSY(b), .BALANCE(bal));
    card_authorizer #(.AUTH_LATENCY(1), .BAL_W(8), .INIT_BALANCE(10)) dut1 (
        .CLK(clk), .RESET(rst_n), .CARD_IN(card), .COST(cost), .VEND(vend), .FAILED_TRAN(fail),
        .TOPUP_EN(ten), .TOPUP_AMT(tamt), .VALID_TRAN(v1), .DENIED(d1), .BUSY(b1), .BALANCE(bal1));
    card_authorizer #(.AUTH_LATENCY(4), .BAL_W(8), .INIT_BALANCE(10)) dut4 (
        .CLK(clk), .RESET(rst_n), .CARD_IN(card), .COST(cost), .VEND(vend), .FAILED_TRAN(fail),
        .TOPUP_EN(ten), .TOPUP_AMT(tamt), .VALID_TRAN(v4), .DENIED(d4), .BUSY(b4), .BALANCE(bal4));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask
    task automatic drive(input string tag, input logic r, input logic c, input logic [2:0] cs,
                         input logic vn, input logic fl, input logic te, input logic [7:0] ta,
                         input logic ev, input logic ed, input logic eb, input logic [7:0] ebal,
                         input bit sw = 1'b0, input logic ev1 = 1'b0, input logic ev4 = 1'b0);
        exp_t e;
        rst_n = r; card = c; cost = cs; vend = vn; fail = fl; ten = te; tamt = ta;
        e.tag = tag; e.v = ev; e.d = ed; e.b = eb; e.bal = ebal; e.sw = sw; e.v1 = ev1; e.v4 = ev4;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin : mon
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".valid"}, 32'(v), 32'(e.v));
            check({e.tag, ".denied"}, 32'(d), 32'(e.d));
            check({e.tag, ".busy"}, 32'(b), 32'(e.b));
            check({e.tag, ".balance"}, 32'(bal), 32'(e.bal));
            if (e.sw) begin
                check({e.tag, ".valid_l1"}, 32'(v1), 32'(e.v1));
                check({e.tag, ".valid_l4"}, 32'(v4), 32'(e.v4));
                check({e.tag, ".denied_l1"}, 32'(d1), 32'(e.d));
                check({e.tag, ".denied_l4"}, 32'(d4), 32'(e.d));
                check({e.tag, ".busy_l1"}, 32'(b1), 32'(e.b));
                check({e.tag, ".busy_l4"}, 32'(b4), 32'(e.b));
                check({e.tag, ".bal_l1"}, 32'(bal1), 32'(e.bal));
                check({e.tag, ".bal_l4"}, 32'(bal4), 32'(e.bal));
            end
        end
    end
    initial begin
        //    tag           rst card cost vend fail ten amt   v  d  b  bal
        drive("reset0",     0,  0,  0,   0,   0,   0,  0,    0, 0, 0, 10);
        drive("reset1",     0,  0,  0,   0,   0,   0,  0,    0, 0, 0, 10);
        drive("g_cap",      1,  1,  3,   0,   0,   0,  0,    0, 0, 1, 10);
        drive("g_wait",     1,  1,  3,   0,   0,   0,  0,    0, 0, 1, 10);
        drive("g_dec",      1,  1,  3,   0,   0,   0,  0,    1, 0, 1, 10);
        drive("g_hold",     1,  1,  3,   0,   0,   0,  0,    1, 0, 1, 10);
        drive("g_vend",     1,  1,  3,   1,   0,   0,  0,    0, 0, 1, 7);
        drive("g_stale",    1,  1,  3,   0,   0,   0,  0,    0, 0, 1, 7);
        drive("g_idle",     1,  1,  0,   0,   0,   0,  0,    0, 0, 0, 7);
        drive("p_cap",      1,  1,  5,   0,   0,   0,  0,    0, 0, 1, 7);
        drive("p_wait",     1,  1,  5,   0,   0,   0,  0,    0, 0, 1, 7);
        drive("p_dec",      1,  1,  5,   0,   0,   0,  0,    1, 0, 1, 7);
        drive("p_vend",     1,  1,  5,   1,   0,   0,  0,    0, 0, 1, 2);
        drive("p_idle",     1,  1,  0,   0,   0,   0,  0,    0, 0, 0, 2);
        drive("d_cap",      1,  1,  5,   0,   0,   0,  0,    0, 0, 1, 2);
        drive("d_wait",     1,  1,  5,   0,   0,   0,  0,    0, 0, 1, 2);
        drive("d_dec",      1,  1,  5,   0,   0,   0,  0,    0, 1, 1, 2);
        drive("d_hold1",    1,  1,  5,   0,   0,   0,  0,    0, 0, 1, 2);
        drive("d_hold2",    1,  1,  5,   0,   0,   0,  0,    0, 0, 1, 2);
        drive("d_idle",     1,  1,  0,   0,   0,   0,  0,    0, 0, 0, 2);
        drive("a_topup",    1,  0,  0,   0,   0,   1,  8,    0, 0, 0, 10);
        drive("a_cap",      1,  1,  4,   0,   0,   0,  0,    0, 0, 1, 10);
        drive("a_wait",     1,  1,  4,   0,   0,   0,  0,    0, 0, 1, 10);
        drive("a_dec",      1,  1,  4,   0,   0,   0,  0,    1, 0, 1, 10);
        drive("a_failed",   1,  1,  0,   0,   1,   0,  0,    0, 0, 0, 10);
        drive("c_cap",      1,  1,  4,   0,   0,   0,  0,    0, 0, 1, 10);
        drive("c_drop",     1,  0,  4,   0,   0,   0,  0,    0, 0, 0, 10);
        drive("c_quiet1",   1,  0,  4,   0,   0,   0,  0,    0, 0, 0, 10);
        drive("c_quiet2",   1,  0,  4,   0,   0,   0,  0,    0, 0, 0, 10);
        drive("s_topup",    1,  0,  0,   0,   0,   1,  240,  0, 0, 0, 250);
        drive("s_cap",      1,  1,  6,   0,   0,   0,  0,    0, 0, 1, 250);
        drive("s_wait",     1,  1,  6,   0,   0,   0,  0,    0, 0, 1, 250);
        drive("s_dec",      1,  1,  6,   0,   0,   0,  0,    1, 0, 1, 250);
        drive("s_sat",      1,  1,  6,   1,   0,   1,  20,   0, 0, 1, 255);
        drive("s_idle",     1,  1,  0,   0,   0,   0,  0,    0, 0, 0, 255);
        drive("t_reset",    0,  0,  0,   0,   0,   0,  0,    0, 0, 0, 10);
        drive("t_cap",      1,  1,  7,   0,   0,   0,  0,    0, 0, 1, 10);
        drive("t_wait",     1,  1,  7,   0,   0,   0,  0,    0, 0, 1, 10);
        drive("t_dec",      1,  1,  7,   0,   0,   0,  0,    1, 0, 1, 10);
        drive("t_vend",     1,  1,  7,   1,   0,   0,  0,    0, 0, 1, 3);
        drive("t_idle",     1,  1,  0,   0,   0,   0,  0,    0, 0, 0, 3);
        drive("u_cap",      1,  1,  6,   0,   0,   0,  0,    0, 0, 1, 3);
        drive("u_topup",    1,  1,  6,   0,   0,   1,  4,    0, 0, 1, 7);
        drive("u_grant",    1,  1,  6,   0,   0,   0,  0,    1, 0, 1, 7);
        drive("u_vend_win", 1,  1,  6,   1,   1,   0,  0,    0, 0, 1, 1);
        drive("u_idle",     1,  1,  0,   0,   0,   0,  0,    0, 0, 0, 1);
        drive("r_cap",      1,  1,  1,   0,   0,   0,  0,    0, 0, 1, 1);
        drive("r_wait",     1,  1,  1,   0,   0,   0,  0,    0, 0, 1, 1);
        drive("r_dec",      1,  1,  1,   0,   0,   0,  0,    1, 0, 1, 1);
        drive("r_reset",    0,  1,  1,   0,   0,   0,  0,    0, 0, 0, 10, 1, 0, 0);
        drive("r_release",  1,  0,  0,   0,   0,   0,  0,    0, 0, 0, 10, 1, 0, 0);
        drive("l_e0",       1,  1,  2,   0,   0,   0,  0,    0, 0, 1, 10, 1, 0, 0);
        drive("l_e1",       1,  1,  2,   0,   0,   0,  0,    0, 0, 1, 10, 1, 1, 0);
        drive("l_e2",       1,  1,  2,   0,   0,   0,  0,    1, 0, 1, 10, 1, 1, 0);
        drive("l_e3",       1,  1,  2,   0,   0,   0,  0,    1, 0, 1, 10, 1, 1, 0);
        drive("l_e4",       1,  1,  2,   0,   0,   0,  0,    1, 0, 1, 10, 1, 1, 1);
        drive("l_drop",     1,  0,  0,   0,   0,   0,  0,    0, 0, 0, 10, 1, 0, 0);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
